md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Execute-stage multiply/divide unit for the P7 pipeline.
- Consumes the 4-bit mdOp code produced by instruction decode and owns the architectural HI/LO registers.
- Models multi-cycle latency with a busy counter so the hazard logic can stall later md instructions.
- Supports exception-driven cancellation, because an instruction in E must not commit when an exception or interrupt is taken in M.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd/msub when enabled); must be at least 1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- md_op  in  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9 madd (optional), 10 msub (optional), others none.
- rs_val  in  32  forwarded rs operand.
- rt_val  in  32  forwarded rt operand.
- cancel  in  1  exception/interrupt flush; suppresses acceptance of md_op this cycle.
- start  out  1  combinational: md_op is a multi-cycle op AND not cancel AND not busy.
- busy  out  1  registered: operation in flight.
- hi  out  32  architectural HI register.
- lo  out  32  architectural LO register.
- md_rdata  out  32  combinational read: hi when md_op=7, lo when md_op=8, else 0.

Behaviour:
- Reset (asynchronous, active-low): busy=0, counter=0, hi=0, lo=0, pending result=0. Reset mid-operation aborts the operation; HI/LO stay 0 after release.
- Accept rule: md_op is sampled at a rising edge only when cancel=0 and busy=0. Any md_op while busy=1 is ignored; the hazard unit stalls the pipeline on start|busy for md ops 1-10.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, counter>0).
- IDLE -> RUN on an accepted op 1-4 (or 9/10 when enabled).
  - Operands are captured and the 64-bit result is computed into pending_hi/pending_lo at the accepting edge.
  - counter loads MULT_CYCLES or DIV_CYCLES.
- RUN: counter decrements each edge. On the edge where counter goes 1->0, hi/lo take the pending values and busy falls in the same edge.
- Timing: accept at edge T; busy=1 from T through T+N; new hi/lo and busy=0 become visible after edge T+N, with N = the op's cycle count.
- mult: signed 32x32 -> 64; hi=upper, lo=lower.
- multu: unsigned 32x32 -> 64.
- div: signed divide; lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
- divu: unsigned divide.
- Divide by zero (rt_val=0): busy behaves normally for DIV_CYCLES; hi/lo are left unchanged at completion.
- div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrap, no trap).
- mthi/mtlo: hi/lo written from rs_val at the accepting edge; single cycle, busy stays 0. Not accepted while busy.
- mfhi/mflo: purely combinational read of the current registers; they never change state.
- cancel=1: nothing is accepted that cycle (no start, no mthi/mtlo write). An operation already in RUN is unaffected and completes.
- md_op arriving on the same edge that busy falls is still ignored, because busy is high at that edge. It is accepted on the next edge if still presented.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: md_op 9 (madd) computes {hi,lo} + signed(rs*rt); md_op 10 (msub) computes {hi,lo} - signed(rs*rt). Both use 64-bit wrap-around and MULT_CYCLES latency. The accumulation uses the hi/lo value at the accepting edge.
- Undefined: codes 9/10 are treated as none: start=0, no state change.

Test Plan:
- mult rs=0xFFFFFFFF rt=0x00000002 -> start=1, busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles. A second mult presented during busy is ignored and accepted only after busy falls.
- div rs=0xFFFFFFF9 (-7) rt=0x00000002 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu rs=7 rt=0 -> after 10 cycles hi/lo remain unchanged.
- mthi rs=0x12345678, then mflo/mfhi -> hi=0x12345678 next cycle, busy stays 0, md_rdata=0x12345678 when md_op=7. Same mthi with cancel=1 -> hi unchanged.
- mult started, reset asserted at busy cycle 3 -> busy=0, hi=lo=0 immediately (asynchronous), and no late update after reset release.
- (MDU_MADD_EN) hi=0, lo=0xFFFFFFFF, madd rs=1 rt=1 -> hi=0x00000001, lo=0x00000000 after 5 cycles. Without the macro, the same stimulus leaves hi/lo unchanged and start=0.

Source files
------------

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO and models multi-cycle latency with a busy counter.
// Optional madd/msub (md_op 9/10) are built only when MDU_MADD_EN is defined.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        cancel,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rdata
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MSUB  = 4'd10
    } md_op_e;

    state_e             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_load;
    logic [63:0]        pend;
    logic               pend_wr;

    logic [63:0]        prod_s, prod_u, res;
    logic               res_wr, is_multi, mt_wr;
    logic [31:0]        a_mag, b_mag, b_safe, q_mag, r_mag, q_s, r_s;
    logic [31:0]        u_div, q_u, r_u;

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps instead of overflowing.
    always_comb begin
        prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
        prod_u = {32'd0, rs_val} * {32'd0, rt_val};
        a_mag  = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
        b_mag  = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
        b_safe = (b_mag == '0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        q_s    = (rs_val[31] ^ rt_val[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s    = rs_val[31] ? (~r_mag + 32'd1) : r_mag;
        u_div  = (rt_val == '0) ? 32'd1 : rt_val;
        q_u    = rs_val / u_div;
        r_u    = rs_val % u_div;
    end

    always_comb begin
        res      = '0;
        res_wr   = 1'b0;
        is_multi = 1'b0;
        cnt_load = CNT_W'(MULT_CYCLES);
        case (md_op)
            OP_MULT: begin
                is_multi = 1'b1;
                res      = prod_s;
                res_wr   = 1'b1;
            end
            OP_MULTU: begin
                is_multi = 1'b1;
                res      = prod_u;
                res_wr   = 1'b1;
            end
            OP_DIV: begin
                is_multi = 1'b1;
                res      = {r_s, q_s};
                res_wr   = (rt_val != '0);
                cnt_load = CNT_W'(DIV_CYCLES);
            end
            OP_DIVU: begin
                is_multi = 1'b1;
                res      = {r_u, q_u};
                res_wr   = (rt_val != '0);
                cnt_load = CNT_W'(DIV_CYCLES);
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                is_multi = 1'b1;
                res      = {hi, lo} + prod_s;
                res_wr   = 1'b1;
            end
            OP_MSUB: begin
                is_multi = 1'b1;
                res      = {hi, lo} - prod_s;
                res_wr   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (cnt == CNT_W'(1)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == S_RUN);
        start    = is_multi && !cancel && (state == S_IDLE);
        mt_wr    = !cancel && (state == S_IDLE);
        md_rdata = '0;
        if (md_op == OP_MFHI)      md_rdata = hi;
        else if (md_op == OP_MFLO) md_rdata = lo;
    end

    // Results are computed at acceptance and only committed on the final busy edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            pend    <= '0;
            pend_wr <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else if (start) begin
            cnt     <= cnt_load;
            pend    <= res;
            pend_wr <= res_wr;
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1) && pend_wr) begin
                hi <= pend[63:32];
                lo <= pend[31:0];
            end
        end else if (mt_wr) begin
            if (md_op == OP_MTHI)      hi <= rs_val;
            else if (md_op == OP_MTLO) lo <= rs_val;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: arithmetic reference model compared every cycle, plus literal checks.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        cancel = 1'b0;
    logic        start, busy;
    logic [31:0] hi, lo, md_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // reference state
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_pend = '0;
    bit          m_pwr = 1'b0;
    int          m_rem = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(rst_n), .md_op(md_op), .rs_val(rs_val), .rt_val(rt_val),
        .cancel(cancel), .start(start), .busy(busy), .hi(hi), .lo(lo), .md_rdata(md_rdata)
    );

    always #5 clk = ~clk;

    function automatic bit multi_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op >= 4'd1 && op <= 4'd4) || op == 4'd9 || op == 4'd10;
`else
        return (op >= 4'd1 && op <= 4'd4);
`endif
    endfunction

    function automatic int op_latency(input logic [3:0] op);
        return (op == 4'd3 || op == 4'd4) ? 10 : 5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the operand values, latency as a countdown of cycles.
    always @(posedge clk or negedge rst_n) begin
        longint      sa, sb, q, r;
        logic [63:0] p;
        if (!rst_n) begin
            m_hi = '0; m_lo = '0; m_pend = '0; m_pwr = 1'b0; m_rem = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_pwr) {m_hi, m_lo} = m_pend;
        end else if (!cancel) begin
            sa = longint'($signed(rs_val));
            sb = longint'($signed(rt_val));
            if (multi_op(md_op)) begin
                m_rem = op_latency(md_op);
                m_pwr = 1'b1;
            end
            case (md_op)
                4'd1: m_pend = 64'(sa * sb);
                4'd2: m_pend = {32'd0, rs_val} * {32'd0, rt_val};
                4'd3: begin
                    if (rt_val == 0) m_pwr = 1'b0;
                    else begin
                        q = sa / sb;
                        r = sa % sb;
                        m_pend = {r[31:0], q[31:0]};
                    end
                end
                4'd4: begin
                    if (rt_val == 0) m_pwr = 1'b0;
                    else m_pend = {rs_val % rt_val, rs_val / rt_val};
                end
                4'd5: m_hi = rs_val;
                4'd6: m_lo = rs_val;
                4'd9, 4'd10: begin
                    p = 64'(sa * sb);
                    if (md_op == 4'd9) m_pend = {m_hi, m_lo} + p;
                    else               m_pend = {m_hi, m_lo} - p;
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_rem > 0));
            check("start", 32'(start), 32'(multi_op(md_op) && !cancel && m_rem == 0));
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            check("md_rdata", md_rdata, (md_op == 4'd7) ? m_hi : (md_op == 4'd8) ? m_lo : 32'd0);
        end
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic c);
        @(posedge clk);
        #2;
        md_op = op; rs_val = a; rt_val = b; cancel = c;
    endtask

    // Present op for one edge, then count cycles with busy high (bounded).
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
        drive(op, a, b, 1'b0);
        drive(4'd0, '0, '0, 1'b0);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            cyc++;
        end
        if (busy) check("busy_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        #8 rst_n = 1'b1;

        run_op(4'd1, 32'hFFFFFFFF, 32'h2, cyc);
        check("mult_cycles", 32'(cyc), 32'd5);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFE);

        run_op(4'd2, 32'hFFFFFFFF, 32'h2, cyc);
        check("multu_cycles", 32'(cyc), 32'd5);
        check("multu_hi", hi, 32'h00000001);
        check("multu_lo", lo, 32'hFFFFFFFE);

        // second mult held through busy: ignored until the edge after busy falls
        drive(4'd1, 32'hFFFFFFFF, 32'h2, 1'b0);
        for (int i = 0; i < 6; i++) drive(4'd1, 32'd3, 32'd3, 1'b0);
        @(negedge clk);
        check("held_busy", 32'(busy), 32'd0);
        check("held_start", 32'(start), 32'd1);
        check("held_first_lo", lo, 32'hFFFFFFFE);
        drive(4'd0, '0, '0, 1'b0);
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        @(negedge clk);
        check("held_second_hi", hi, 32'd0);
        check("held_second_lo", lo, 32'd9);

        run_op(4'd3, 32'hFFFFFFF9, 32'h2, cyc);
        check("div_cycles", 32'(cyc), 32'd10);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        run_op(4'd4, 32'd7, 32'd0, cyc);
        check("divz_cycles", 32'(cyc), 32'd10);
        check("divz_lo", lo, 32'hFFFFFFFD);
        check("divz_hi", hi, 32'hFFFFFFFF);

        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, cyc);
        check("divov_lo", lo, 32'h80000000);
        check("divov_hi", hi, 32'd0);

        run_op(4'd4, 32'd100, 32'd7, cyc);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        run_op(4'd5, 32'h12345678, '0, cyc);
        check("mthi_busy", 32'(cyc), 32'd0);
        check("mthi_hi", hi, 32'h12345678);
        drive(4'd7, '0, '0, 1'b0);
        @(negedge clk);
        check("mfhi_rdata", md_rdata, 32'h12345678);
        drive(4'd8, '0, '0, 1'b0);
        @(negedge clk);
        check("mflo_rdata", md_rdata, 32'd14);
        drive(4'd5, 32'hDEADBEEF, '0, 1'b1);
        drive(4'd1, 32'd5, 32'd5, 1'b1);
        @(negedge clk);
        check("cancel_start", 32'(start), 32'd0);
        drive(4'd0, '0, '0, 1'b0);
        @(negedge clk);
        check("cancel_hi", hi, 32'h12345678);
        check("cancel_busy", 32'(busy), 32'd0);

        drive(4'd5, 32'd0, '0, 1'b0);
        drive(4'd6, 32'hFFFFFFFF, '0, 1'b0);
        drive(4'd9, 32'd1, 32'd1, 1'b0);
        @(negedge clk);
`ifdef MDU_MADD_EN
        check("madd_start", 32'(start), 32'd1);
`else
        check("madd_start", 32'(start), 32'd0);
`endif
        drive(4'd0, '0, '0, 1'b0);
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        @(negedge clk);
`ifdef MDU_MADD_EN
        check("madd_hi", hi, 32'd1);
        check("madd_lo", lo, 32'd0);
        run_op(4'd10, 32'd2, 32'd3, cyc);
        check("msub_hi", hi, 32'd0);
        check("msub_lo", lo, 32'hFFFFFFFA);
`else
        check("madd_hi", hi, 32'd0);
        check("madd_lo", lo, 32'hFFFFFFFF);
`endif

        // asynchronous reset in the middle of a mult
        drive(4'd1, 32'hFFFFFFFF, 32'h2, 1'b0);
        drive(4'd0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("rst_after_hi", hi, 32'd0);
        check("rst_after_lo", lo, 32'd0);
        check("rst_after_busy", 32'(busy), 32'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
